// File: rtl/seq_store_aligner_pkg.sv
// rtl/seq_store_aligner_pkg.sv - shared types, sizes and helpers for the sequential store aligner
//
// Purpose: beat geometry (BusBytes from lane count and DLEN), request meta,
// sequential-buffer beat and store write-beat structs, and small helpers
// that turn nibble enables into byte strobes / byte masks.
package seq_store_aligner_pkg;

  localparam int DLEN        = 64;
  localparam int DefNrLanes  = 4;
  localparam int DefMaxBeats = 256;
  localparam int BusBytes    = DefNrLanes * DLEN / 8;
  localparam int OffW        = $clog2(BusBytes);
  localparam int NrBeatsW    = $clog2(DefMaxBeats + 1);
  localparam int ReqIdW      = 4;

  typedef struct packed {
    logic [ReqIdW-1:0]   req_id;
    logic [NrBeatsW-1:0] nr_beats;
    logic [OffW-1:0]     byte_off;
  } seq_store_meta_t;

  // Nibble 2b is the low half of byte b, nibble 2b+1 the high half.
  typedef struct packed {
    logic [BusBytes*2-1:0][3:0] nb;
    logic [BusBytes*2-1:0]      en;
  } seq_buf_t;

  typedef struct packed {
    logic [BusBytes*8-1:0] data;
    logic [BusBytes-1:0]   strb;
    logic                  last;
    logic [ReqIdW-1:0]     req_id;
  } seq_store_w_t;

  // A byte is written when its low nibble is enabled; the high nibble must agree.
  function automatic logic [BusBytes-1:0] nib_en_to_bstrb(input logic [BusBytes*2-1:0] en);
    logic [BusBytes-1:0] bstrb;
    bstrb = '0;
    for (int b = 0; b < BusBytes; b++) bstrb[b] = en[2*b];
    return bstrb;
  endfunction

  function automatic logic nib_en_consistent(input logic [BusBytes*2-1:0] en);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < BusBytes; b++) if (en[2*b] != en[2*b+1]) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [BusBytes*8-1:0] strb_to_mask(input logic [BusBytes-1:0] strb);
    logic [BusBytes*8-1:0] m;
    m = '0;
    for (int b = 0; b < BusBytes; b++) m[b*8 +: 8] = {8{strb[b]}};
    return m;
  endfunction

endpackage

// File: rtl/seq_store_aligner_byte_rotator.sv
// rtl/seq_store_aligner_byte_rotator.sv - combinational byte shift by off with carry merge
//
// Purpose: shifts an input beat up by off bytes; the low off bytes are filled
// from the carry of the previous beat, the bytes pushed out the top become the
// new carry (left-aligned at byte 0, zero above off).
// Ports:
//   data_i/strb_i             input beat bytes and byte strobes
//   off_i                     byte misalignment
//   carry_data_i/carry_strb_i carry from the previous beat (zero above off)
//   data_o/strb_o             shifted beat merged with the carry
//   carry_data_o/carry_strb_o carry for the next beat
module seq_store_aligner_byte_rotator
  import seq_store_aligner_pkg::*;
(
  input  logic [BusBytes*8-1:0] data_i,
  input  logic [BusBytes-1:0]   strb_i,
  input  logic [OffW-1:0]       off_i,
  input  logic [BusBytes*8-1:0] carry_data_i,
  input  logic [BusBytes-1:0]   carry_strb_i,
  output logic [BusBytes*8-1:0] data_o,
  output logic [BusBytes-1:0]   strb_o,
  output logic [BusBytes*8-1:0] carry_data_o,
  output logic [BusBytes-1:0]   carry_strb_o
);

  logic [2*BusBytes*8-1:0] data_sh;
  logic [2*BusBytes-1:0]   strb_sh;

  // Double-width shift: the low half is the aligned beat, the high half the spill.
  assign data_sh = {{(BusBytes*8){1'b0}}, data_i} << {off_i, 3'b000};
  assign strb_sh = {{BusBytes{1'b0}}, strb_i} << off_i;

  // Shifted-in low bytes are zero and the carry is zero above off, so OR merges.
  assign data_o       = data_sh[BusBytes*8-1:0] | carry_data_i;
  assign strb_o       = strb_sh[BusBytes-1:0] | carry_strb_i;
  assign carry_data_o = data_sh[2*BusBytes*8-1:BusBytes*8];
  assign carry_strb_o = strb_sh[2*BusBytes-1:BusBytes];

endmodule

// File: rtl/seq_store_aligner.sv
// rtl/seq_store_aligner.sv - aligns sequential store beats by byte offset into bus write beats
//
// Purpose: per request (meta), consumes nr_beats sequential-buffer beats,
// shifts them up by byte_off, converts nibble enables to byte strobes and
// emits registered write beats; a misaligned request gets one extra flush beat
// holding the final carry. One request in flight at a time.
// Optional macro: VLSU_SEQ_STORE_ZERO_MASKED_EN forces strobe-0 data bytes to 0.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   meta_valid_i/ready_o, meta_i  request meta handshake
//   rx_valid_i/ready_o, rx_i      sequential beat input
//   w_valid_o/w_ready_i, w_o      write beat output (data, strb, last, req_id)
//   busy_o                        a request is being processed
module seq_store_aligner
  import seq_store_aligner_pkg::*;
#(
  parameter int NrLanes  = DefNrLanes,
  parameter int MaxBeats = DefMaxBeats
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            meta_valid_i,
  output logic            meta_ready_o,
  input  seq_store_meta_t meta_i,
  input  logic            rx_valid_i,
  output logic            rx_ready_o,
  input  seq_buf_t        rx_i,
  output logic            w_valid_o,
  input  logic            w_ready_i,
  output seq_store_w_t    w_o,
  output logic            busy_o
);

  localparam int BeatBytes = NrLanes * DLEN / 8;
  localparam int CntW      = $clog2(MaxBeats + 1);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d, nr_beats_q, nr_beats_d;
  logic [OffW-1:0]        off_q, off_d;
  logic [ReqIdW-1:0]      req_id_q, req_id_d;
  logic [BeatBytes*8-1:0] carry_data_q, carry_data_d;
  logic [BeatBytes-1:0]   carry_strb_q, carry_strb_d;
  logic                   w_valid_q, w_valid_d;
  seq_store_w_t           w_q, w_d;

  logic [BeatBytes*8-1:0] rot_data, rot_carry_data;
  logic [BeatBytes-1:0]   rot_strb, rot_carry_strb;
  logic                   out_free;

  seq_store_aligner_byte_rotator u_rot (
    .data_i       (rx_i.nb),
    .strb_i       (nib_en_to_bstrb(rx_i.en)),
    .off_i        (off_q),
    .carry_data_i (carry_data_q),
    .carry_strb_i (carry_strb_q),
    .data_o       (rot_data),
    .strb_o       (rot_strb),
    .carry_data_o (rot_carry_data),
    .carry_strb_o (rot_carry_strb)
  );

  // Output register can take a new beat when empty or draining this cycle.
  assign out_free = !w_valid_q || w_ready_i;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    nr_beats_d   = nr_beats_q;
    off_d        = off_q;
    req_id_d     = req_id_q;
    carry_data_d = carry_data_q;
    carry_strb_d = carry_strb_q;
    w_d          = w_q;
    w_valid_d    = w_valid_q && !w_ready_i;
    meta_ready_o = 1'b0;
    rx_ready_o   = 1'b0;
    case (state_q)
      IDLE: begin
        meta_ready_o = 1'b1;
        if (meta_valid_i) begin
          req_id_d     = meta_i.req_id;
          nr_beats_d   = meta_i.nr_beats;
          off_d        = meta_i.byte_off;
          cnt_d        = '0;
          carry_data_d = '0;
          carry_strb_d = '0;
          state_d      = STREAM;
        end
      end
      STREAM: begin
        rx_ready_o = out_free;
        if (rx_valid_i && out_free) begin
          cnt_d        = cnt_q + CntW'(1);
          carry_data_d = rot_carry_data;
          carry_strb_d = rot_carry_strb;
          w_d.data     = rot_data;
          w_d.strb     = rot_strb;
          w_d.req_id   = req_id_q;
          w_d.last     = 1'b0;
          w_valid_d    = 1'b1;
          if (cnt_d == nr_beats_q) begin
            if (off_q == '0) begin
              w_d.last = 1'b1;
              state_d  = IDLE;
            end else begin
              state_d  = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          w_d.data   = carry_data_q;
          w_d.strb   = carry_strb_q;
          w_d.req_id = req_id_q;
          w_d.last   = 1'b1;
          w_valid_d  = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef VLSU_SEQ_STORE_ZERO_MASKED_EN
    w_d.data = w_d.data & strb_to_mask(w_d.strb);
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      nr_beats_q   <= '0;
      off_q        <= '0;
      req_id_q     <= '0;
      carry_data_q <= '0;
      carry_strb_q <= '0;
      w_valid_q    <= 1'b0;
      w_q          <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      nr_beats_q   <= nr_beats_d;
      off_q        <= off_d;
      req_id_q     <= req_id_d;
      carry_data_q <= carry_data_d;
      carry_strb_q <= carry_strb_d;
      w_valid_q    <= w_valid_d;
      w_q          <= w_d;
    end
  end

  assign w_valid_o = w_valid_q;
  assign w_o       = w_q;
  assign busy_o    = (state_q != IDLE);

  a_nib_en_pairs: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (rx_valid_i && rx_ready_o) |-> nib_en_consistent(rx_i.en));

  a_nr_beats_nonzero: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (meta_valid_i && meta_ready_o) |-> (meta_i.nr_beats != '0));

endmodule
